// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate data cache, one-word lines: same-cycle hits, misses via RAM port.
// Halt flushes dirty lines, writes the hit count to HITCNT_ADDR, then holds flushed until reset.
module dcache_responder #(
  parameter int          SETS        = 16,
  parameter logic [31:0] HITCNT_ADDR = 32'h0000_3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        flushed
);
  localparam int IDX = $clog2(SETS);
  localparam int TW  = 30 - IDX;

  typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, CNT, DONE} state_t;

  state_t          state_q, state_d;
  logic [IDX-1:0]  fidx_q, fidx_d;
  logic [31:0]     hitcnt_q, hitcnt_d;
  logic            valid_q [SETS];
  logic            dirty_q [SETS];
  logic [TW-1:0]   tag_q   [SETS];
  logic [31:0]     data_q  [SETS];

  logic [IDX-1:0]  idx;
  logic [TW-1:0]   rtag;
  logic            req, hit, fl_dirty;
  logic            unused_lsb;

  assign idx        = dmemaddr[IDX+1:2];
  assign rtag       = dmemaddr[31:IDX+2];
  assign req        = dmemREN | dmemWEN;
  assign hit        = valid_q[idx] && (tag_q[idx] == rtag);
  assign fl_dirty   = valid_q[fidx_q] && dirty_q[fidx_q];
  assign unused_lsb = ^dmemaddr[1:0];

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    flushed  = 1'b0;
    state_d  = state_q;
    fidx_d   = fidx_q;
    hitcnt_d = hitcnt_q;
    case (state_q)
      IDLE: begin
        // A pending request always wins over halt so the pipeline is never left stalled.
        if (req && hit) begin
          dhit     = 1'b1;
          dmemload = data_q[idx];
          hitcnt_d = hitcnt_q + 32'd1;
        end else if (req) begin
          state_d = dirty_q[idx] ? WB : FETCH;
        end else if (halt) begin
          state_d = FLUSH;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = {tag_q[idx], idx, 2'b00};
        dstore = data_q[idx];
        if (!dwait) state_d = FETCH;
      end
      FETCH: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) state_d = IDLE;
      end
      FLUSH: begin
        if (fl_dirty) begin
          dWEN   = 1'b1;
          daddr  = {tag_q[fidx_q], fidx_q, 2'b00};
          dstore = data_q[fidx_q];
        end
        if (!fl_dirty || !dwait) begin
          fidx_d = fidx_q + IDX'(1);
          if (&fidx_q) state_d = CNT;
        end
      end
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HITCNT_ADDR;
        dstore = hitcnt_q;
        if (!dwait) state_d = DONE;
      end
      DONE:    flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q  <= IDLE;
      fidx_q   <= '0;
      hitcnt_q <= '0;
      for (int i = 0; i < SETS; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      fidx_q   <= fidx_d;
      hitcnt_q <= hitcnt_d;
      case (state_q)
        IDLE: if (dhit && dmemWEN) begin
          data_q[idx]  <= dmemstore;
          dirty_q[idx] <= 1'b1;
        end
        WB: if (!dwait) dirty_q[idx] <= 1'b0;
        FETCH: if (!dwait) begin
          data_q[idx]  <= dload;
          tag_q[idx]   <= rtag;
          valid_q[idx] <= 1'b1;
          dirty_q[idx] <= 1'b0;
        end
        FLUSH: if (fl_dirty && !dwait) dirty_q[fidx_q] <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Memory-stage responder for the data-memory request interface driven by the EX/MEM→MEM pipeline stage (dmemREN/dmemWEN/dmemaddr/dmemstore).
- Direct-mapped, write-back, write-allocate data cache with one-word lines. Answers hits with dhit in the same cycle and resolves misses against the RAM port.
- On halt, writes back every dirty line, stores the hit count to HITCNT_ADDR, then asserts flushed.

Parameters:
- SETS, 16, number of lines (power of 2); index = dmemaddr[IDX+1:2], IDX = log2(SETS); tag = dmemaddr[31:IDX+2].
- HITCNT_ADDR, 32'h0000_3100, RAM word address receiving the hit count at the end of the flush.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- nRST  in  1  reset. Synchronous, active-high (asserted = 1); the name is kept for the codebase's naming.
- halt  in  1  pipeline halted; level, sampled in IDLE.
- dmemREN  in  1  pipeline read request.
- dmemWEN  in  1  pipeline write request.
- dmemaddr  in  32  request byte address; bits [1:0] ignored.
- dmemstore  in  32  write data.
- dmemload  out  32  read data, valid when dhit=1.
- dhit  out  1  request satisfied this cycle.
- dREN  out  1  RAM read request.
- dWEN  out  1  RAM write request.
- daddr  out  32  RAM word address, bits [1:0]=0.
- dstore  out  32  RAM write data.
- dload  in  32  RAM read data, valid when dwait=0.
- dwait  in  1  RAM busy; a transaction completes in a cycle with dREN|dWEN=1 and dwait=0.
- flushed  out  1  flush complete; held until reset.

Behaviour:
- Storage per line: valid, dirty, tag, 32-bit data. hitcnt is a 32-bit register.
- Reset, with nRST=1 sampled at an edge:
  - All valid and dirty bits cleared; hitcnt=0; flush index=0; state=IDLE.
  - Outputs combinational from state: dhit=0, dmemload=0, dREN=0, dWEN=0, daddr=0, dstore=0, flushed=0.
  - Reset mid-transaction abandons the transaction; no line is updated on that edge.
- Request: req = dmemREN|dmemWEN. If both are asserted, the request is treated as a write.
- hit = valid[idx] && tag[idx]==tag(dmemaddr).
- State IDLE:
  - req && hit: dhit=1 combinationally and dmemload=data[idx].
  - Write hit: at the edge, data[idx]=dmemstore and dirty[idx]=1.
  - Every cycle with dhit=1, hitcnt increments by 1 (wraps at 2^32).
  - req && !hit && dirty[idx]: go to WB. req && !hit && !dirty[idx]: go to FETCH.
  - !req && halt: go to FLUSH. A request takes priority over halt.
- State WB:
  - dWEN=1, daddr={tag[idx],idx,2'b00}, dstore=data[idx].
  - On dwait=0, clear dirty[idx] and go to FETCH.
- State FETCH:
  - dREN=1, daddr={dmemaddr[31:2],2'b00}.
  - On dwait=0: data[idx]=dload, tag updated, valid=1, dirty=0, then go to IDLE.
  - dhit stays 0 for the whole miss. The retried request hits on the first IDLE cycle, so a miss costs WB+FETCH latency plus 1 cycle.
- Address stability: the pipeline holds the request stable until dhit. The cache does not latch the address.
- State FLUSH:
  - Walks flush index i = 0..SETS-1.
  - If valid[i]&&dirty[i]: dWEN=1, daddr={tag[i],i,2'b00}, dstore=data[i]; on dwait=0, clear dirty[i] and advance i.
  - Clean or invalid lines advance i in one cycle with no RAM access.
  - After i=SETS-1 completes, go to CNT.
- State CNT:
  - dWEN=1, daddr=HITCNT_ADDR, dstore=hitcnt.
  - On dwait=0, go to DONE.
- State DONE: flushed=1 and all RAM outputs 0. Absorbing until reset.
- In FLUSH, CNT and DONE, pipeline requests are ignored (dhit=0) and hitcnt is frozen.
- dwait is honoured indefinitely: outputs are held stable while it stays high.

Test Plan:
- Reset, then read 0x40 with RAM returning 0xDEADBEEF after 2 dwait cycles → dREN high 3 cycles with daddr=0x40, dhit=0 throughout, then dhit=1 with dmemload=0xDEADBEEF on the next cycle; hitcnt=1.
- Write 0x1234 to 0x40 (line now present), then read 0x40 → dhit same cycle both times, no RAM traffic, dmemload=0x1234, hitcnt=3.
- Read 0x80 (same index as 0x40, dirty) → dWEN with daddr=0x40, dstore=0x1234, then dREN with daddr=0x80, then dhit=1.
- Lines 0 and 3 dirty, halt=1 → exactly two writebacks (indices 0 and 3), then write of hitcnt to 0x3100, then flushed=1 and held.
- Assert nRST during FETCH with dwait=1 → next cycle dREN=0 and state IDLE; a re-request to the same address misses again.
- Assert halt together with a pending miss → the miss completes and dhit=1 before FLUSH begins.
